mem_store_checker: RTL and testbench
====================================

// Module: mem_store_checker
// PURPOSE
//  Synthesizable self-check monitor on the risc_v_32_i data-store bus (value_from_alu / data_to_write /
//  writting_to_mem). Generalises the single "addr 100 = 25" pass check to a parametrised table of
//  expected stores, checked in-order or any-order, with data-mismatch detection and a cycle timeout.
//  Sits beside the core in benches and on FPGA builds; drives pass/fail flags and diagnostic capture.
// PARAMETERS
//  XLEN        32       store address/data width
//  NUM_CHECKS  4        entries in expected-store table (>=1)
//  ORDERED     1        1: entries must complete in index order; 0: any order
//  TIMEOUT     100000   cycles in RUN before FAIL; 0 disables timeout
// PORTS
//  clk         in   1                  clock; all state on rising edge
//  reset       in   1                  asynchronous, active-low reset
//  start       in   1                  arm checker (honoured in IDLE, PASS, FAIL)
//  mem_write   in   1                  store strobe (writting_to_mem)
//  mem_addr    in   XLEN               store address (value_from_alu)
//  mem_wdata   in   XLEN               store data (data_to_write)
//  exp_addr    in   NUM_CHECKS*XLEN    expected addresses, entry i at [i*XLEN +: XLEN]; static while RUN
//  exp_data    in   NUM_CHECKS*XLEN    expected data, same packing
//  busy        out  1                  FSM in RUN
//  pass        out  1                  sticky: all entries matched
//  fail        out  1                  sticky: mismatch or timeout
//  timed_out   out  1                  sticky: fail cause was timeout
//  hit_mask    out  NUM_CHECKS         entries matched so far
//  fail_addr   out  XLEN               address of offending store (0 on timeout)
//  fail_data   out  XLEN               data of offending store (0 on timeout)
//  cycles      out  32                 cycles spent in RUN, saturating at 2^32-1
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; every output 0. Release takes effect at the next edge.
//  - FSM IDLE -> RUN on start; RUN -> PASS / FAIL; PASS/FAIL -> RUN on start (clears hit_mask, pass,
//    fail, timed_out, fail_addr, fail_data, cycles). start while RUN ignored.
//  - Store sampled only on edges where state==RUN and mem_write=1; store coincident with start ignored.
//  - ORDERED=1: let k = lowest unhit index. addr==exp_addr[k] & data==exp_data[k] -> set hit[k].
//    addr==exp_addr[k] & data!=exp_data[k] -> FAIL. Any other address (incl. later entries) ignored.
//  - ORDERED=0: among unhit entries with addr match, lowest index whose data also matches is hit.
//    Addr matches >=1 unhit entry but no data match -> FAIL. Stores to already-hit-only or unlisted
//    addresses ignored. At most one entry hit per store.
//  - FAIL on mismatch captures mem_addr/mem_wdata into fail_addr/fail_data on the same edge.
//  - Latency: pass/fail visible the cycle after the deciding store edge (registered outputs).
//  - PASS when hit_mask becomes all-ones. Final hit and timeout on the same edge -> PASS wins.
//  - Timeout: cycles increments each RUN edge; when cycles reaches TIMEOUT-1 without completion,
//    next edge -> FAIL with timed_out=1. TIMEOUT=0: never times out; cycles still counts and saturates.
//  - pass and fail never both 1. Outputs hold in PASS/FAIL until start or reset.
//  - Reset asserted mid-RUN: immediate return to IDLE, all outputs 0, no partial result kept.
// STRUCTURE
//  - Shared package riscv_tb_pkg: chk_state_t enum {IDLE, RUN, PASS, FAIL}; typedef xlen_word_t;
//    constant RISCV_XLEN=32; pass signature constants PASS_ADDR=100, PASS_DATA=25.
//  - One sub-module: cycle_timeout_counter (saturating 32-bit counter, clear/enable, terminal flag).
//  - Match logic (per-entry comparators, lowest-index priority pick) stays in this module.
// TESTING
//  1. NUM_CHECKS=1, table {100:25}; start, then store (100,25) -> pass=1 next cycle, fail=0, hit_mask=1.
//  2. ORDERED=1, table {100:25,104:7}; stores (104,7),(100,25),(104,7) -> first ignored, pass after third.
//  3. ORDERED=0, same table; store (100,26) -> fail=1, fail_addr=100, fail_data=26, timed_out=0.
//  4. TIMEOUT=50, no stores after start -> fail=1, timed_out=1 after 50 RUN cycles, cycles=50.
//  5. Final matching store on timeout edge -> pass=1, fail=0; then start -> all status cleared, busy=1.
//  6. Drop reset mid-RUN with hit_mask=1 -> all outputs 0 immediately; store (100,25) w/o start ignored.

Source files
------------

// File: rtl/mem_store_checker_pkg.sv
// Shared types and constants for the RISC-V store-bus self-check monitor.
package riscv_tb_pkg;
  localparam int          RISCV_XLEN = 32;
  localparam logic [31:0] PASS_ADDR  = 32'd100;
  localparam logic [31:0] PASS_DATA  = 32'd25;

  typedef logic [RISCV_XLEN-1:0] xlen_word_t;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} chk_state_t;
endpackage

// File: rtl/cycle_timeout_counter.sv
// Saturating 32-bit cycle counter with synchronous clear, enable and a
// terminal flag raised when the count sits one below TIMEOUT (0 disables it).
module cycle_timeout_counter #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  output logic [31:0] o_count,
  output logic        o_terminal
);
  logic [31:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_count <= '0;
    else if (i_clr)                   r_count <= '0;
    else if (i_en && r_count != '1)   r_count <= r_count + 32'd1;
  end

  generate
    if (TIMEOUT == 0) begin : g_no_to
      assign o_terminal = 1'b0;
    end else begin : g_to
      assign o_terminal = (r_count == 32'(TIMEOUT - 1));
    end
  endgenerate

  assign o_count = r_count;
endmodule

// File: rtl/mem_store_checker.sv
// Store-bus monitor: matches observed stores against a table of expected
// (addr, data) pairs, in index order or any order, with a cycle timeout.
module mem_store_checker
  import riscv_tb_pkg::*;
#(
  parameter int          XLEN       = RISCV_XLEN,
  parameter int          NUM_CHECKS = 4,
  parameter int          ORDERED    = 1,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mem_write,
  input  logic [XLEN-1:0]            mem_addr,
  input  logic [XLEN-1:0]            mem_wdata,
  input  logic [NUM_CHECKS*XLEN-1:0] exp_addr,
  input  logic [NUM_CHECKS*XLEN-1:0] exp_data,
  output logic                       busy,
  output logic                       pass,
  output logic                       fail,
  output logic                       timed_out,
  output logic [NUM_CHECKS-1:0]      hit_mask,
  output logic [XLEN-1:0]            fail_addr,
  output logic [XLEN-1:0]            fail_data,
  output logic [31:0]                cycles
);
  chk_state_t            r_state;
  logic                  r_busy, r_pass, r_fail, r_timed_out;
  logic [NUM_CHECKS-1:0] r_hit;
  logic [XLEN-1:0]       r_fail_addr, r_fail_data;

  logic [NUM_CHECKS-1:0] w_addr_eq, w_data_eq, w_cand, w_full, w_hit_vec, w_hit_next;
  logic                  w_mismatch, w_all_hit, w_term, w_clr, w_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHECKS; gi++) begin : g_cmp
      assign w_addr_eq[gi] = (mem_addr  == exp_addr[gi*XLEN +: XLEN]);
      assign w_data_eq[gi] = (mem_wdata == exp_data[gi*XLEN +: XLEN]);
    end
  endgenerate

  assign w_cand = ~r_hit & w_addr_eq;
  assign w_full = w_cand & w_data_eq;

  // Ordered mode only ever looks at the lowest unhit entry; unordered mode
  // picks the lowest unhit entry that matches both address and data.
  always_comb begin
    logic found;
    w_hit_vec  = '0;
    w_mismatch = 1'b0;
    found      = 1'b0;
    if (ORDERED != 0) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        if (!found && !r_hit[i]) begin
          found = 1'b1;
          if (w_addr_eq[i]) begin
            if (w_data_eq[i]) w_hit_vec[i] = 1'b1;
            else              w_mismatch   = 1'b1;
          end
        end
      end
    end else begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        if (!found && w_full[i]) begin
          w_hit_vec[i] = 1'b1;
          found        = 1'b1;
        end
      end
      w_mismatch = (|w_cand) && !(|w_full);
    end
  end

  assign w_hit_next = r_hit | w_hit_vec;
  assign w_all_hit  = &w_hit_next;
  assign w_clr      = start && (r_state != RUN);
  assign w_en       = (r_state == RUN);

  cycle_timeout_counter #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .i_clr      (w_clr),
    .i_en       (w_en),
    .o_count    (cycles),
    .o_terminal (w_term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timed_out <= 1'b0;
      r_hit       <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (mem_write && w_mismatch) begin
            r_state     <= FAIL;
            r_busy      <= 1'b0;
            r_fail      <= 1'b1;
            r_fail_addr <= mem_addr;
            r_fail_data <= mem_wdata;
          end else if (mem_write && w_all_hit) begin
            // completion beats a coincident timeout
            r_state <= PASS;
            r_busy  <= 1'b0;
            r_pass  <= 1'b1;
            r_hit   <= w_hit_next;
          end else begin
            if (mem_write) r_hit <= w_hit_next;
            if (w_term) begin
              r_state     <= FAIL;
              r_busy      <= 1'b0;
              r_fail      <= 1'b1;
              r_timed_out <= 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timed_out <= 1'b0;
            r_hit       <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
          end
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign timed_out = r_timed_out;
  assign hit_mask  = r_hit;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;
endmodule

// File: tb/tb_mem_store_checker.sv
// Directed bench: three checker configurations share one store bus; a vector
// table drives the ordered two-entry checker, hand sequences cover the rest.
module tb_mem_store_checker;
  logic        clk = 1'b0;
  logic        rst_n, start, we;
  logic [31:0] addr, data;

  logic [31:0] a_ea = 32'd100, a_ed = 32'd25;
  logic [63:0] bc_ea = {32'd104, 32'd100};
  logic [63:0] bc_ed = {32'd7,   32'd25};

  logic        a_busy, a_pass, a_fail, a_to;
  logic [0:0]  a_hit;
  logic [31:0] a_fa, a_fd, a_cyc;
  logic        b_busy, b_pass, b_fail, b_to;
  logic [1:0]  b_hit;
  logic [31:0] b_fa, b_fd, b_cyc;
  logic        c_busy, c_pass, c_fail, c_to;
  logic [1:0]  c_hit;
  logic [31:0] c_fa, c_fd, c_cyc;

  int n_tot  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_store_checker #(.XLEN(32), .NUM_CHECKS(1), .ORDERED(1), .TIMEOUT(50)) u_a (
    .clk(clk), .reset(rst_n), .start(start), .mem_write(we), .mem_addr(addr), .mem_wdata(data),
    .exp_addr(a_ea), .exp_data(a_ed), .busy(a_busy), .pass(a_pass), .fail(a_fail),
    .timed_out(a_to), .hit_mask(a_hit), .fail_addr(a_fa), .fail_data(a_fd), .cycles(a_cyc));

  mem_store_checker #(.XLEN(32), .NUM_CHECKS(2), .ORDERED(1), .TIMEOUT(0)) u_b (
    .clk(clk), .reset(rst_n), .start(start), .mem_write(we), .mem_addr(addr), .mem_wdata(data),
    .exp_addr(bc_ea), .exp_data(bc_ed), .busy(b_busy), .pass(b_pass), .fail(b_fail),
    .timed_out(b_to), .hit_mask(b_hit), .fail_addr(b_fa), .fail_data(b_fd), .cycles(b_cyc));

  mem_store_checker #(.XLEN(32), .NUM_CHECKS(2), .ORDERED(0), .TIMEOUT(0)) u_c (
    .clk(clk), .reset(rst_n), .start(start), .mem_write(we), .mem_addr(addr), .mem_wdata(data),
    .exp_addr(bc_ea), .exp_data(bc_ed), .busy(c_busy), .pass(c_pass), .fail(c_fail),
    .timed_out(c_to), .hit_mask(c_hit), .fail_addr(c_fa), .fail_data(c_fd), .cycles(c_cyc));

  typedef struct {
    logic        s, w;
    logic [31:0] a, d;
    logic        eb, ep, ef;
    logic [1:0]  eh;
    logic [31:0] efa, efd, ec;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(logic s, logic w, logic [31:0] a, logic [31:0] d,
                              logic eb, logic ep, logic ef, logic [1:0] eh,
                              logic [31:0] efa, logic [31:0] efd, logic [31:0] ec);
    vec_t v;
    v.s = s; v.w = w; v.a = a; v.d = d;
    v.eb = eb; v.ep = ep; v.ef = ef; v.eh = eh;
    v.efa = efa; v.efd = efd; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; data = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    // ordered table on the {100:25, 104:7} checker
    tbl[0]  = mk(1, 0,   0,  0, 1, 0, 0, 2'b00,   0,  0, 0);
    tbl[1]  = mk(0, 1, 104,  7, 1, 0, 0, 2'b00,   0,  0, 1);
    tbl[2]  = mk(0, 1, 100, 25, 1, 0, 0, 2'b01,   0,  0, 2);
    tbl[3]  = mk(0, 0,   0,  0, 1, 0, 0, 2'b01,   0,  0, 3);
    tbl[4]  = mk(0, 1, 100, 25, 1, 0, 0, 2'b01,   0,  0, 4);
    tbl[5]  = mk(0, 1, 104,  7, 0, 1, 0, 2'b11,   0,  0, 5);
    tbl[6]  = mk(1, 1, 100, 25, 1, 0, 0, 2'b00,   0,  0, 0);
    tbl[7]  = mk(0, 1, 104,  8, 1, 0, 0, 2'b00,   0,  0, 1);
    tbl[8]  = mk(0, 1, 100, 24, 0, 0, 1, 2'b00, 100, 24, 2);
    tbl[9]  = mk(0, 0,   0,  0, 0, 0, 1, 2'b00, 100, 24, 2);
    tbl[10] = mk(1, 0,   0,  0, 1, 0, 0, 2'b00,   0,  0, 0);
    tbl[11] = mk(1, 1, 100, 25, 1, 0, 0, 2'b01,   0,  0, 1);

    rst_n = 1'b0; start = 1'b0; we = 1'b0; addr = '0; data = '0;
    #12;
    chk("rst.a_busy", 32'(a_busy), 0);
    chk("rst.a_pass", 32'(a_pass), 0);
    chk("rst.a_fail", 32'(a_fail), 0);
    chk("rst.b_hit",  32'(b_hit),  0);
    chk("rst.b_cyc",  b_cyc,       0);
    rst_n = 1'b1;

    // single-entry pass
    kick();
    chk("t1.busy", 32'(a_busy), 1);
    store(100, 25);
    chk("t1.pass", 32'(a_pass), 1);
    chk("t1.fail", 32'(a_fail), 0);
    chk("t1.hit",  32'(a_hit),  1);
    chk("t1.cyc",  a_cyc,       1);

    // timeout after 50 RUN cycles
    kick();
    repeat (49) cyc();
    chk("t4.busy49", 32'(a_busy), 1);
    chk("t4.cyc49",  a_cyc,       49);
    chk("t4.fail49", 32'(a_fail), 0);
    cyc();
    chk("t4.fail", 32'(a_fail), 1);
    chk("t4.to",   32'(a_to),   1);
    chk("t4.cyc",  a_cyc,       50);
    chk("t4.fa",   a_fa,        0);
    chk("t4.pass", 32'(a_pass), 0);

    // final hit on the timeout edge wins
    kick();
    repeat (49) cyc();
    store(100, 25);
    chk("t5.pass", 32'(a_pass), 1);
    chk("t5.fail", 32'(a_fail), 0);
    chk("t5.to",   32'(a_to),   0);
    chk("t5.cyc",  a_cyc,       50);
    kick();
    chk("t5.busy", 32'(a_busy), 1);
    chk("t5.clrp", 32'(a_pass), 0);
    chk("t5.clrh", 32'(a_hit),  0);
    chk("t5.clrc", a_cyc,       0);
    store(100, 9);
    chk("t5.mfail", 32'(a_fail), 1);
    chk("t5.mfa",   a_fa,        100);
    chk("t5.mfd",   a_fd,        9);
    kick();
    chk("t5.clrf",  32'(a_fail), 0);
    chk("t5.clrfa", a_fa,        0);
    chk("t5.clrfd", a_fd,        0);

    // ordered checker has been running since the first start: entry 0 hit only
    chk("t6.pre_hit",  32'(b_hit),  1);
    chk("t6.pre_busy", 32'(b_busy), 1);
    rst_n = 1'b0;
    #2;
    chk("t6.busy", 32'(b_busy), 0);
    chk("t6.hit",  32'(b_hit),  0);
    chk("t6.cyc",  b_cyc,       0);
    chk("t6.a_busy", 32'(a_busy), 0);
    rst_n = 1'b1;
    store(100, 25);
    chk("t6.nostart_hit",  32'(b_hit),  0);
    chk("t6.nostart_busy", 32'(b_busy), 0);
    chk("t6.nostart_pass", 32'(b_pass), 0);

    for (int i = 0; i < 12; i++) begin
      start = tbl[i].s; we = tbl[i].w; addr = tbl[i].a; data = tbl[i].d;
      cyc();
      start = 1'b0; we = 1'b0;
      chk($sformatf("vec%0d.busy", i), 32'(b_busy), 32'(tbl[i].eb));
      chk($sformatf("vec%0d.pass", i), 32'(b_pass), 32'(tbl[i].ep));
      chk($sformatf("vec%0d.fail", i), 32'(b_fail), 32'(tbl[i].ef));
      chk($sformatf("vec%0d.to",   i), 32'(b_to),   0);
      chk($sformatf("vec%0d.hit",  i), 32'(b_hit),  32'(tbl[i].eh));
      chk($sformatf("vec%0d.fa",   i), b_fa,        tbl[i].efa);
      chk($sformatf("vec%0d.fd",   i), b_fd,        tbl[i].efd);
      chk($sformatf("vec%0d.cyc",  i), b_cyc,       tbl[i].ec);
    end

    // unordered checker from a clean reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    kick();
    store(100, 26);
    chk("t3.fail", 32'(c_fail), 1);
    chk("t3.fa",   c_fa,        100);
    chk("t3.fd",   c_fd,        26);
    chk("t3.to",   32'(c_to),   0);
    kick();
    store(104, 7);
    chk("u.hit1",  32'(c_hit),  2);
    chk("u.busy1", 32'(c_busy), 1);
    store(104, 9);
    chk("u.hit2",  32'(c_hit),  2);
    chk("u.fail2", 32'(c_fail), 0);
    store(300, 1);
    chk("u.busy3", 32'(c_busy), 1);
    store(100, 25);
    chk("u.pass",  32'(c_pass), 1);
    chk("u.hit4",  32'(c_hit),  3);
    chk("u.cyc4",  c_cyc,       4);
    chk("u.fail4", 32'(c_fail), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
